// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first,
// WIDTH clocks per operation, registered sum/cout/ovf under a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry_out, sum_bit} for one full-adder slice.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  state_t               state, state_n;
  logic [WIDTH-1:0]     a_sr, a_sr_n;
  logic [WIDTH-1:0]     b_sr, b_sr_n;
  logic [WIDTH-2:0]     res_sr, res_sr_n;
  logic                 carry, carry_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [WIDTH-1:0]     sum_n;
  logic                 cout_n, ovf_n;
  logic [1:0]           slice;
  logic [WIDTH-1:0]     res_full;

  assign slice    = full_add(a_sr[0], b_sr[0], carry);
  // Result bits accumulate in the low WIDTH-1 positions; the MSB step supplies the top bit.
  assign res_full = {slice[0], res_sr};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_n  = state;
    a_sr_n   = a_sr;
    b_sr_n   = b_sr;
    res_sr_n = res_sr;
    carry_n  = carry;
    cnt_n    = cnt;
    sum_n    = sum;
    cout_n   = cout;
    ovf_n    = ovf;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_sr_n  = a;
          b_sr_n  = sub ? ~b : b;
          carry_n = sub;
          cnt_n   = '0;
          state_n = RUN;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        a_sr_n   = a_sr >> 1;
        b_sr_n   = b_sr >> 1;
        res_sr_n = res_full[WIDTH-1:1];
        carry_n  = slice[1];
        cnt_n    = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          // carry still holds the carry into the MSB here.
          sum_n   = res_full;
          cout_n  = slice[1];
          ovf_n   = carry ^ slice[1];
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      a_sr   <= a_sr_n;
      b_sr   <= b_sr_n;
      res_sr <= res_sr_n;
      carry  <= carry_n;
      cnt    <= cnt_n;
      sum    <= sum_n;
      cout   <= cout_n;
      ovf    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH 8/2/32 instances, cycle-level arithmetic model
// checked every cycle, plus directed vectors with literal expected results.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v, start_v, sub_v;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  a8, b8, sum8;
  logic [1:0]  a2, b2, sum2;
  logic [31:0] a32, b32, sum32;
  logic [63:0] a_d [3];
  logic [63:0] b_d [3];

  int passed = 0;
  int total  = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sub(sub_v[0]), .a(a8), .b(b8),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum8), .cout(cout_v[0]), .ovf(ovf_v[0])
  );
  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sub(sub_v[1]), .a(a2), .b(b2),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum2), .cout(cout_v[1]), .ovf(ovf_v[1])
  );
  serial_adder #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .sub(sub_v[2]), .a(a32), .b(b32),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum32), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  function automatic int wid(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 2 : 32);
  endfunction

  function automatic logic [63:0] msk(input int k);
    return (64'd1 << wid(k)) - 64'd1;
  endfunction

  function automatic logic [63:0] get_sum(input int k);
    case (k)
      0:       return {56'd0, sum8};
      1:       return {62'd0, sum2};
      default: return {32'd0, sum32};
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input int k, input logic s, input logic sb,
                       input logic [63:0] av, input logic [63:0] bv);
    start_v[k] = s;
    sub_v[k]   = sb;
    a_d[k]     = av & msk(k);
    b_d[k]     = bv & msk(k);
    case (k)
      0:       begin a8  = av[7:0];  b8  = bv[7:0];  end
      1:       begin a2  = av[1:0];  b2  = bv[1:0];  end
      default: begin a32 = av[31:0]; b32 = bv[31:0]; end
    endcase
  endtask

  // Reference model: plain modular arithmetic and a cycle countdown.
  int          left  [3];
  logic        mdone [3];
  logic        live  [3];
  logic [63:0] esum  [3];
  logic [63:0] psum  [3];
  logic        ecout [3], eovf [3], pcout [3], povf [3];

  initial for (int k = 0; k < 3; k++) begin
    left[k] = 0; mdone[k] = 1'b0; live[k] = 1'b0;
    esum[k] = '0; psum[k] = '0; ecout[k] = 1'b0; eovf[k] = 1'b0; pcout[k] = 1'b0; povf[k] = 1'b0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k] === 1'b1) begin
        left[k] = 0; mdone[k] = 1'b0; esum[k] = '0; ecout[k] = 1'b0; eovf[k] = 1'b0;
        live[k] = 1'b1;
      end else if (left[k] > 0) begin
        left[k]  = left[k] - 1;
        mdone[k] = (left[k] == 0);
        if (left[k] == 0) begin
          esum[k] = psum[k]; ecout[k] = pcout[k]; eovf[k] = povf[k];
        end
      end else begin
        mdone[k] = 1'b0;
        if (start_v[k] === 1'b1) begin
          logic [63:0] bop, full;
          int w;
          w        = wid(k);
          bop      = (sub_v[k] ? ~b_d[k] : b_d[k]) & msk(k);
          full     = a_d[k] + bop + {63'd0, sub_v[k]};
          psum[k]  = full & msk(k);
          pcout[k] = full[w];
          povf[k]  = (a_d[k][w-1] == bop[w-1]) && (psum[k][w-1] != a_d[k][w-1]);
          left[k]  = w;
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      if (live[k]) begin
        check($sformatf("w%0d busy", wid(k)), {63'd0, busy_v[k]}, {63'd0, left[k] > 0});
        check($sformatf("w%0d done", wid(k)), {63'd0, done_v[k]}, {63'd0, mdone[k]});
        check($sformatf("w%0d sum",  wid(k)), get_sum(k), esum[k]);
        check($sformatf("w%0d cout", wid(k)), {63'd0, cout_v[k]}, {63'd0, ecout[k]});
        check($sformatf("w%0d ovf",  wid(k)), {63'd0, ovf_v[k]},  {63'd0, eovf[k]});
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                        input logic sb, output int lat);
    drive(k, 1'b1, sb, av, bv);
    @(negedge clk);
    drive(k, 1'b0, 1'($urandom_range(1)), {$urandom, $urandom}, {$urandom, $urandom});
    lat = 1;
    while (done_v[k] !== 1'b1 && lat < 3 * wid(k) + 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("w%0d latency", wid(k)), 64'(lat), 64'(wid(k) + 1));
  endtask

  task automatic expect8(input string nm, input logic [7:0] s, input logic c, input logic o);
    check({nm, " sum"},  {56'd0, sum8},      {56'd0, s});
    check({nm, " cout"}, {63'd0, cout_v[0]}, {63'd0, c});
    check({nm, " ovf"},  {63'd0, ovf_v[0]},  {63'd0, o});
  endtask

  task automatic test8();
    int lat, nd;
    run_op(0, 'h3C, 'h15, 1'b0, lat); expect8("3C+15", 8'h51, 1'b0, 1'b0);
    @(negedge clk);
    run_op(0, 'hFF, 'h01, 1'b0, lat); expect8("FF+01", 8'h00, 1'b1, 1'b0);
    run_op(0, 'h7F, 'h01, 1'b0, lat); expect8("7F+01", 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    run_op(0, 'h05, 'h07, 1'b1, lat); expect8("05-07", 8'hFE, 1'b0, 1'b0);
    run_op(0, 'h80, 'h01, 1'b1, lat); expect8("80-01", 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
    // Second start mid-RUN must be ignored.
    drive(0, 1'b1, 1'b0, 'h10, 'h20);
    @(negedge clk);
    lat = 1;
    while (done_v[0] !== 1'b1 && lat < 30) begin
      drive(0, lat == 3, 1'b0, 'hAA, 'h55);
      @(negedge clk);
      lat++;
    end
    check("ignored start latency", 64'(lat), 64'd9);
    expect8("10+20", 8'h30, 1'b0, 1'b0);
    // Start accepted in the DONE cycle.
    drive(0, 1'b1, 1'b0, 'h01, 'h01);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 'hF0, 'h0F);
    check("sum held during run", {56'd0, sum8}, 64'h30);
    lat = 1;
    while (done_v[0] !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    check("back-to-back latency", 64'(lat), 64'd9);
    expect8("01+01", 8'h02, 1'b0, 1'b0);
    // Reset four cycles into a run.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 'hC0, 'hC0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 'h00, 'h00);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("rst busy", {63'd0, busy_v[0]}, 64'd0);
    check("rst done", {63'd0, done_v[0]}, 64'd0);
    expect8("rst", 8'h00, 1'b0, 1'b0);
    nd = 0;
    repeat (12) begin @(negedge clk); if (done_v[0] === 1'b1) nd++; end
    check("no done after abort", 64'(nd), 64'd0);
    run_op(0, 'h12, 'h34, 1'b0, lat); expect8("12+34", 8'h46, 1'b0, 1'b0);
  endtask

  task automatic sweep(input int k);
    int lat;
    repeat (1000) begin
      if ($urandom_range(1) == 1) @(negedge clk);
      run_op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), lat);
    end
  endtask

  initial begin
    rst_v   = 3'b111;
    start_v = 3'b000;
    sub_v   = 3'b000;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    rst_v = 3'b000;
    fork
      test8();
      sweep(1);
      sweep(2);
    join
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d of %0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
